// File: rtl/apb_defs.sv
// Shared APB constants and state encodings, reused by the bridge, the APB slaves and their benches.
package apb_defs;

  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  // Wait counter width: enough to hold TIMEOUT, never narrower than one bit.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter; expired flags that PREADY has stayed low for TIMEOUT counted cycles.
module apb_wait_timer
  import apb_defs::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = wait_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // Saturates instead of wrapping so a disabled timeout can never alias a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired && (cnt != {CW{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: single-beat command in, SETUP/ACCESS transfer out, one-cycle response pulse back.
module apb_master_bridge
  import apb_defs::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  output apb_state_e        state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // the requester holds cmd_* stable until then. rsp_valid is a single-cycle pulse
  // with no backpressure; rsp_rdata/rsp_err stay valid until the next completion.

  apb_state_e state;
  logic       expired;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (state == ST_SETUP),
    .en     ((state == ST_ACCESS) && !PREADY),
    .expired(expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_write ? cmd_wdata : '0;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            state     <= ST_IDLE;
          end else if (expired) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign state_dbg = state;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that turns single-beat command requests from an on-chip controller into APB3 transfers. It sits upstream of the UART and GPIO APB slaves on the same PCLK domain. It drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, waits for PREADY, and returns PRDATA with a completion pulse. A configurable timeout aborts transfers to a slave that never asserts PREADY.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 255, max ACCESS cycles with PREADY low before abort; 0 disables the timeout
- PCLK  in  1  APB clock, single clock domain; all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data, ignored for reads
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborts
- rsp_err  out  1  1 = transfer aborted by timeout; valid with rsp_valid
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready

## Operation
- FSM with 3 states:
  - IDLE: cmd_ready = 1. On cmd_valid, latch cmd_write, cmd_addr and cmd_wdata (cmd_wdata forced to 0 for reads), then go to SETUP.
  - SETUP: PSEL = 1, PENABLE = 0. Unconditionally go to ACCESS.
  - ACCESS: PSEL = 1, PENABLE = 1.
    - PREADY = 1: capture PRDATA on reads, go to IDLE.
    - PREADY = 0 and the wait counter equals TIMEOUT (TIMEOUT ≠ 0): go to IDLE with the abort flag set.
    - Otherwise stay in ACCESS and increment the wait counter.
- Wait counter is $clog2(TIMEOUT+1) bits wide (min 1). It clears on SETUP and never wraps; the abort fires first.
- cmd_ready is 1 only in IDLE. cmd_valid in any other state is ignored; the requester holds it.
- rsp_valid is registered and high for exactly the first IDLE cycle after ACCESS exits.
  - rsp_err = 1 on abort; 0 otherwise.
  - rsp_rdata = captured PRDATA for a completed read; 0 for writes and aborts.
  - rsp_rdata and rsp_err hold until the next completion.
- PADDR, PWRITE and PWDATA are registered, stable from SETUP through the last ACCESS cycle, and hold their last values in IDLE.
- A new command accepted in the rsp_valid cycle is legal and starts the next SETUP on the following cycle.
- PREADY and PRDATA are ignored outside ACCESS.
- Reset (asynchronous, any state, including mid-ACCESS):
  - FSM goes to IDLE and the wait counter clears.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata and rsp_err go to 0; cmd_ready = 1.
  - No response is issued for the interrupted transfer.

## Timing
- Cycle 0: IDLE, cmd_valid & cmd_ready.
- Cycle 1: SETUP.
- Cycle 2: ACCESS.
- Each PREADY-low cycle adds one ACCESS cycle.
- rsp_valid asserts one cycle after the ACCESS cycle in which PREADY = 1.
- Zero-wait transfer: command accepted to rsp_valid is 3 cycles; max throughput is one transfer per 3 cycles.
- Abort: PREADY low for TIMEOUT+1 consecutive ACCESS cycles; rsp_valid with rsp_err on the next cycle.
- All outputs come from flops except cmd_ready, which is decoded from the registered state.

## Structure
- Shared APB package/include (apb_defs) holds:
  - state encodings: IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10
  - default ADDR_W, DATA_W and TIMEOUT
  - the same constants reused by the APB slaves and their benches
- One natural sub-module, apb_wait_timer: wait counter plus comparator, with clear/enable inputs and an expired output.
- FSM and datapath registers stay in apb_master_bridge.

## Test plan
- Write, zero-wait slave: cmd addr 0x0000_0010, wdata 0xA5 → PSEL=1/PENABLE=0 for one cycle, then PENABLE=1 with PWDATA=0xA5; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read, zero-wait slave returning 0x0000_0041 → PWRITE=0, PWDATA=0; rsp_rdata=0x41, rsp_err=0.
- Read, slave holds PREADY low 4 cycles → ACCESS lasts 5 cycles; PADDR stable throughout; rsp_valid 7 cycles after accept with correct data.
- TIMEOUT=8, PREADY stuck low → exactly 9 ACCESS cycles, then PSEL=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; next command accepted normally.
- Back-to-back: cmd_valid held high with a write then a read → second SETUP immediately follows the first rsp_valid cycle; 6 cycles total for both.
- PRESET asserted mid-ACCESS (async, between edges) → PSEL/PENABLE drop immediately, no rsp_valid, cmd_ready=1 after release, next transfer correct.
